// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM encoding,
// BCD digit types and the BCD step helpers used by the top.
package timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [6:0] DISPLAY_0 = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } preset_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
        bcd_t tenths;
    } count_t;

    // +1 s on the preset, 99 wraps to 00
    function automatic preset_t preset_inc(preset_t p);
        preset_t r;
        r = p;
        if (p.units == bcd_t'(9)) begin
            r.units = '0;
            r.tens  = (p.tens == bcd_t'(9)) ? '0 : p.tens + bcd_t'(1);
        end else begin
            r.units = p.units + bcd_t'(1);
        end
        return r;
    endfunction

    // -0.1 s with borrow; never called on 00.0
    function automatic count_t count_dec(count_t c);
        count_t r;
        r = c;
        if (c.tenths != '0) begin
            r.tenths = c.tenths - bcd_t'(1);
        end else begin
            r.tenths = bcd_t'(9);
            if (c.units != '0) begin
                r.units = c.units - bcd_t'(1);
            end else begin
                r.units = bcd_t'(9);
                r.tens  = c.tens - bcd_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment pattern (gfedcba); non-BCD codes blank.
module bcd_to_7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/key_pulse.sv
// Push-button conditioning: two-flop synchroniser, edge register and a
// registered one-cycle pulse on each press (1->0 of the synchronised key).
module key_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key};
            prev_q <= sync_q[1];
            pulse  <= prev_q & ~sync_q[1];
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: BCD preset 1..99 s, 0.1 s countdown with pause/resume,
// alarm at 00.0, three registered active-low 7-segment digits.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_COUNT_IN_MS = 100,
    parameter int FREQ_MHZ        = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       KEY1,
    input  logic       KEY2,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       ALARM
);

    localparam int DIV        = FREQ_MHZ * 1000 * MIN_COUNT_IN_MS;
    localparam int DIV_W      = $clog2(DIV);
    localparam int NUM_DIGITS = 3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic start_p, inc_p;

    key_pulse u_key1 (.clk(clk), .rst_n(rst_n), .key(KEY1), .pulse(start_p));
    key_pulse u_key2 (.clk(clk), .rst_n(rst_n), .key(KEY2), .pulse(inc_p));

    state_t             state_q, state_d;
    preset_t            preset_q, preset_d;
    count_t             count_q, count_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               tick, last_step;

    assign tick      = (state_q == RUN) && (presc_q == DIV_LAST);
    assign last_step = (count_q.tens == '0) && (count_q.units == '0) &&
                       (count_q.tenths == bcd_t'(1));

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                if (start_p && (preset_q != '0)) begin
                    count_d = '{tens: preset_q.tens, units: preset_q.units, tenths: '0};
                    presc_d = '0;
                    state_d = RUN;
                end
                if (inc_p) preset_d = preset_inc(preset_q);
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + DIV_W'(1);
                if (tick) count_d = count_dec(count_q);
                // the final tick wins over a coincident pause request
                if (tick && last_step) state_d = DONE;
                else if (start_p)      state_d = PAUSE;
            end
            PAUSE: if (start_p) state_d = RUN;
            DONE:  if (start_p) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] disp;
    logic [NUM_DIGITS-1:0][6:0]         seg, hex_q;

    always_comb begin
        if (state_q == IDLE) disp = {preset_q.tens, preset_q.units, bcd_t'(0)};
        else                 disp = {count_q.tens, count_q.units, count_q.tenths};
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        bcd_to_7seg u_dec (.bcd(disp[i]), .seg(seg[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            preset_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            hex_q    <= {NUM_DIGITS{DISPLAY_0}};
            ALARM    <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            hex_q    <= seg;
            ALARM    <= (state_d == DONE);
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown counterpart of the board stopwatch. The user programs a preset of 1–99 s with a push button. On start, the block counts down in 0.1 s steps and shows the remaining time on three active-low 7-segment digits. When the count reaches 00.0 it raises an alarm output. It sits at board top level next to the stopwatch, driven directly by the 50 MHz board clock and the KEY buttons.

## Interface
- `MIN_COUNT_IN_MS`, default 100: countdown step in milliseconds.
- `FREQ_MHZ`, default 50: clk frequency. The tick divisor `DIV = FREQ_MHZ*1000*MIN_COUNT_IN_MS` clk cycles per step.
- `clk`, input, 1: single clock for everything.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `KEY1`, input, 1: start/pause/acknowledge button. Active-low, asynchronous to clk.
- `KEY2`, input, 1: preset +1 s button. Active-low, asynchronous to clk.
- `HEX0`, output, 7: tenths digit, active-low segments, registered.
- `HEX1`, output, 7: seconds units digit, active-low, registered.
- `HEX2`, output, 7: seconds tens digit, active-low, registered.
- `ALARM`, output, 1: high while in DONE, registered.

## Operation
- **Key conditioning:**
  - Each key passes through 2 synchroniser flops, then an edge register.
  - A press is a one-cycle pulse on the synchronised 1→0 transition.
  - Holding a key produces exactly one pulse. Release produces none.
- **State machine:** states IDLE, RUN, PAUSE, DONE.
  - IDLE:
    - KEY2 pulse: preset += 1 s in BCD (units 9→0 carries into tens; 99→00 wraps).
    - KEY1 pulse with preset ≠ 00: load count = preset:0 (tens, units, tenths = 0), clear the prescaler, go to RUN.
    - KEY1 pulse with preset = 00: ignored.
  - RUN:
    - Each tick decrements the count by 0.1 s as 3-digit BCD with borrow (x0.0 → (x-1)9.9 pattern).
    - A tick that takes the count from 00.1 to 00.0 goes to DONE.
    - KEY1 pulse: go to PAUSE.
  - PAUSE: count and prescaler frozen. KEY1 pulse returns to RUN, resuming the partial tick.
  - DONE: count held at 00.0, `ALARM` = 1. KEY1 pulse goes to IDLE. The preset is retained.
  - KEY2 pulses outside IDLE are ignored.
- **Simultaneous tick and KEY1 pulse in RUN:** the decrement is applied.
  - If the decrement reaches 00.0, go to DONE (the pause is discarded).
  - Otherwise go to PAUSE with the decremented count.
- **Prescaler:** 0..DIV-1 counter, advancing only in RUN.
  - Tick is a one-cycle pulse when the counter equals DIV-1; the counter then wraps to 0.
  - Cleared on IDLE→RUN.
- **Display source:** preset digits (tenths shows 0) in IDLE; count digits in all other states. Digits are encoded through the standard BCD→7-segment active-low map.
- **Digit ranges:** every digit stays within 0–9.

## Timing
- **Reset values (async, immediate on `rst_n` low):**
  - state = IDLE, preset = 00, count = 00.0, prescaler = 0.
  - `ALARM` = 0.
  - `HEX0`/`HEX1`/`HEX2` = 7'b1000000 (digit 0).
  - Synchroniser and edge flops = 1 (key released).
- **Reset mid-operation:** returns to IDLE and loses the preset. No alarm glitch; `ALARM` goes low asynchronously.
- **Key latency:**
  - Key low is first sampled at edge N; the pulse is high during cycle N+2.
  - State, preset and count update at edge N+3.
  - `HEX*` update at edge N+4.
- **Tick period:** exactly DIV clk cycles in RUN. First tick DIV cycles after entering RUN.
- **`ALARM` timing:** rises at the same edge the state becomes DONE. Falls at the edge the state leaves DONE.
- **`HEX*` latency:** always one cycle behind the internal digits.

## Structure
- **Shared package (`timer_pkg`):**
  - state encoding (IDLE, RUN, PAUSE, DONE; 2 bits);
  - `DISPLAY_0` constant (7'b1000000);
  - BCD digit width (4).
- **Sub-module `key_pulse`:** 2-flop synchroniser plus falling-edge pulse, reset to released. Instantiated for KEY1 and KEY2.
- **Reused:** the existing BCD→7-segment decoder, 3 instances.
- **Kept in the top:** state machine, BCD preset/count arithmetic, prescaler, output registers.

## Test plan
Bench parameters: FREQ_MHZ=1, MIN_COUNT_IN_MS=1 (DIV = 1000).
- **Reset:** assert `rst_n` low mid-RUN → `HEX*` = 7'b1000000 at once, `ALARM` = 0, state IDLE, preset 00.
- **Preset and wrap:** 12 KEY2 presses → display 12.0. 100 presses from reset → 00.0 (wrap). KEY1 with preset 00 → stays IDLE.
- **Countdown:** preset 02, KEY1 → display 01.9 after 1000 cycles. Count reaches 00.0 after 20 000 cycles, `ALARM` = 1 at the same edge.
- **Pause/resume:** pause at 01.5 + 400 cycles, hold 5000 cycles, resume → next decrement 600 cycles after resume, to 01.4.
- **Boundaries:**
  - KEY1 pulse coinciding with the final tick → DONE, not PAUSE.
  - KEY1 in DONE → IDLE showing the preset, `ALARM` = 0.
- **Debounce semantics:** key held low 10 000 cycles → exactly one preset increment. KEY2 pulses in RUN → no preset change.
